// File: rtl/sram_rw_wmask.sv
// -----------------------------------------------------------------------------
// sram_rw_wmask
//   Parametrised single-port (1RW) SRAM behavioural model with per-byte write
//   mask, a spare-bit field above the payload, 1- or 2-cycle read latency, a
//   ready/valid status interface and an optional post-reset zero-fill sweep.
//
// Ports
//   clk0         in   clock, all activity on the rising edge
//   rst0         in   asynchronous active-high reset
//   csb0         in   active-low chip select
//   web0         in   active-low write enable (1 = read)
//   wmask0       in   per-byte write enable, bit i covers din0[8i+7:8i]
//   spare_wen0   in   write enable for the spare field (MSBs of din0)
//   addr0        in   word address
//   din0         in   write data, spare field in the MSBs
//   dout0        out  read data, holds its last read value between reads
//   dout_valid0  out  one-cycle pulse when dout0 carries a fresh read result
//   ready0       out  array accepts requests
//   vccd1/vssd1  inout power pins, present only with USE_POWER_PINS
// -----------------------------------------------------------------------------
module sram_rw_wmask #(
  parameter int DATA_WIDTH    = 32,
  parameter int SPARE_BITS    = 1,
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LAT      = 1,
  parameter int INIT_ON_RESET = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                                vccd1,
  inout  wire                                vssd1,
`endif
  input  logic                               clk0,
  input  logic                               rst0,
  input  logic                               csb0,
  input  logic                               web0,
  input  logic [DATA_WIDTH/8-1:0]            wmask0,
  input  logic                               spare_wen0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  input  logic [DATA_WIDTH+SPARE_BITS-1:0]   din0,
  output logic [DATA_WIDTH+SPARE_BITS-1:0]   dout0,
  output logic                               dout_valid0,
  output logic                               ready0
);

  localparam int WORD_WIDTH = DATA_WIDTH + SPARE_BITS;
  localparam int NUM_BYTES  = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  // The sweep counter carries one extra bit so the terminal value never
  // aliases with address 0.
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  // Elaboration-time parameter checks.
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("sram_rw_wmask: READ_LAT must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("sram_rw_wmask: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control FSM: zero-fill sweep followed by normal operation
  // ---------------------------------------------------------------------------
  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   cnt_reg;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic                  ready_reg;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Registered so ready0 is low throughout reset regardless of the
      // state the FSM resets into.
      ready_reg <= (state_next == ST_RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CNT) begin
          state_next = ST_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  assign ready0 = ready_reg;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  logic wr_acc;
  logic rd_acc;
  logic sweep_we;

  assign wr_acc = ready_reg && !csb0 && !web0;
  assign rd_acc = ready_reg && !csb0 &&  web0;

  // The state register sits at INIT while rst0 is held; gating with rst0
  // keeps the array untouched by reset itself.
  assign sweep_we = (state_reg == ST_INIT) && !rst0;

  // Expand the byte mask and the spare enable into a per-bit write mask.
  logic [WORD_WIDTH-1:0] wbit_mask;

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_mask
    assign wbit_mask[8*gi +: 8] = {8{wmask0[gi]}};
  end

  if (SPARE_BITS > 0) begin : g_spare_mask
    assign wbit_mask[WORD_WIDTH-1:DATA_WIDTH] = {SPARE_BITS{spare_wen0}};
  end

  // ---------------------------------------------------------------------------
  // Array write and registered read
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] rd_q_reg;

  always_ff @(posedge clk0) begin
    if (sweep_we) begin
      mem[cnt_reg[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < WORD_WIDTH; k++) begin
        if (wbit_mask[k]) begin
          mem[addr0][k] <= din0[k];
        end
      end
    end
    // Reads and writes are mutually exclusive on this single port, so the
    // sampled word is always the contents before any later write.
    if (rd_acc) begin
      rd_q_reg <= mem[addr0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: the valid chain is reset so in-flight reads are discarded.
  // ---------------------------------------------------------------------------
  logic                  rd_vld_reg;
  logic [WORD_WIDTH-1:0] pipe_data;
  logic                  pipe_vld;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      rd_vld_reg <= 1'b0;
    end else begin
      rd_vld_reg <= rd_acc;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [WORD_WIDTH-1:0] rd_q2_reg;
    logic                  rd_vld2_reg;

    always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
        rd_q2_reg   <= '0;
        rd_vld2_reg <= 1'b0;
      end else begin
        rd_vld2_reg <= rd_vld_reg;
        if (rd_vld_reg) begin
          rd_q2_reg <= rd_q_reg;
        end
      end
    end

    assign pipe_data = rd_q2_reg;
    assign pipe_vld  = rd_vld2_reg;
  end else begin : g_lat1
    assign pipe_data = rd_q_reg;
    assign pipe_vld  = rd_vld_reg;
  end

  // Output register: dout0 only moves on a completed read, so it holds its
  // last value across writes, idles and dropped requests.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout0       <= '0;
      dout_valid0 <= 1'b0;
    end else begin
      dout_valid0 <= pipe_vld;
      if (pipe_vld) begin
        dout0 <= pipe_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_rw_wmask.sv
// -----------------------------------------------------------------------------
// tb_sram_rw_wmask
//   Self-checking bench for sram_rw_wmask (ADDR_WIDTH=4, READ_LAT=2,
//   INIT_ON_RESET=1). Read expectations are queued when a read is driven and
//   compared (data and arrival cycle) when dout_valid0 pulses.
// -----------------------------------------------------------------------------
module tb_sram_rw_wmask;

  localparam int DW    = 32;
  localparam int SB    = 1;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int WW    = DW + SB;
  localparam int DEPTH = 1 << AW;

  logic            clk0 = 1'b0;
  logic            rst0;
  logic            csb0;
  logic            web0;
  logic [DW/8-1:0] wmask0;
  logic            spare_wen0;
  logic [AW-1:0]   addr0;
  logic [WW-1:0]   din0;
  logic [WW-1:0]   dout0;
  logic            dout_valid0;
  logic            ready0;

  sram_rw_wmask #(
    .DATA_WIDTH   (DW),
    .SPARE_BITS   (SB),
    .ADDR_WIDTH   (AW),
    .READ_LAT     (LAT),
    .INIT_ON_RESET(1)
  ) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .csb0       (csb0),
    .web0       (web0),
    .wmask0     (wmask0),
    .spare_wen0 (spare_wen0),
    .addr0      (addr0),
    .din0       (din0),
    .dout0      (dout0),
    .dout_valid0(dout_valid0),
    .ready0     (ready0)
  );

  always #5 clk0 = ~clk0;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  typedef struct {
    logic [WW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [WW-1:0] exp_mem [DEPTH];
  logic [WW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [WW-1:0] merge(input logic [WW-1:0] old, input logic [WW-1:0] d,
                                          input logic [DW/8-1:0] m, input logic sw);
    logic [WW-1:0] r;
    r = old;
    for (int b = 0; b < DW/8; b++) begin
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    if (sw) r[WW-1] = d[WW-1];
    return r;
  endfunction

  always @(posedge clk0) cyc <= cyc + 1;

  // Output monitor: every valid pulse must match the oldest pending read.
  always @(negedge clk0) begin
    if (dout_valid0) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 64'(dout_valid0), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_data", 64'(dout0), 64'(mon_e.data));
        check("rd_cycle", 64'(cyc), 64'(mon_e.due));
        last_rd = mon_e.data;
      end
    end
  end

  task automatic drive_write(input int a, input logic [WW-1:0] d, input logic [DW/8-1:0] m,
                             input logic sw, input bit accepted);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b0; addr0 = AW'(a); din0 = d; wmask0 = m; spare_wen0 = sw;
    if (accepted) exp_mem[a] = merge(exp_mem[a], d, m, sw);
  endtask

  task automatic drive_read(input int a, input logic [WW-1:0] exp);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(a); wmask0 = '0; spare_wen0 = 1'b0;
    din0 = '0;
    sb_q.push_back('{data: exp, due: cyc + 1 + LAT});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk0);
      csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; spare_wen0 = 1'b0;
    end
  endtask

  // Release reset at a falling edge and measure how long ready0 stays low.
  task automatic release_and_count(input string tag);
    int n;
    @(negedge clk0);
    rst0 = 1'b0;
    n = 0;
    while (!ready0 && n < 100) begin
      @(posedge clk0);
      #1;
      n++;
    end
    check(tag, 64'(n), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; spare_wen0 = 1'b0;
    addr0 = '0; din0 = '0;

    // Reset state
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    check("rst_ready", 64'(ready0), 64'd0);
    check("rst_dout", 64'(dout0), 64'd0);
    check("rst_valid", 64'(dout_valid0), 64'd0);

    // Test 1: sweep length and zero-filled array
    release_and_count("init_cycles");
    for (int a = 0; a < DEPTH; a++) drive_read(a, exp_mem[a]);
    idle(LAT + 1);

    // Test 2: byte-masked write, spare not written
    drive_write(5, 33'h1_DEADBEEF, 4'b0101, 1'b0, 1'b1);
    drive_read(5, 33'h0_00AD00EF);
    // Spare-only write, then a full no-op write
    drive_write(6, 33'h1_FFFFFFFF, 4'b0000, 1'b1, 1'b1);
    drive_write(5, 33'h1_12345678, 4'b0000, 1'b0, 1'b1);
    drive_read(6, 33'h1_00000000);
    drive_read(5, 33'h0_00AD00EF);
    idle(LAT + 1);

    // Test 3: back-to-back reads with READ_LAT=2
    drive_write(1, 33'h0_0000000A, 4'hF, 1'b1, 1'b1);
    drive_write(2, 33'h0_0000000B, 4'hF, 1'b1, 1'b1);
    drive_write(3, 33'h0_0000000C, 4'hF, 1'b1, 1'b1);
    drive_read(1, 33'h0_0000000A);
    drive_read(2, 33'h0_0000000B);
    drive_read(3, 33'h0_0000000C);
    idle(LAT + 1);

    // Test 4: read then write same address, then re-read
    drive_write(7, 33'h0_00000011, 4'hF, 1'b0, 1'b1);
    drive_read(7, exp_mem[7]);
    drive_write(7, 33'h0_00000022, 4'hF, 1'b0, 1'b1);
    drive_read(7, exp_mem[7]);
    drive_write(9, 33'h1_CAFEF00D, 4'b1010, 1'b1, 1'b1);
    drive_read(9, exp_mem[9]);
    idle(LAT + 1);

    // Test 6b: deselected cycles produce no valid and dout0 holds
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1; addr0 = 4'd3;
    repeat (4) @(negedge clk0);
    check("hold_dout", 64'(dout0), 64'(last_rd));
    check("hold_valid", 64'(dout_valid0), 64'd0);

    // Reset in RUN with a read in flight: ready drops at once, read discarded
    drive_read(3, exp_mem[3]);
    @(negedge clk0);
    csb0 = 1'b1;
    #2;
    rst0 = 1'b1;
    sb_q.delete();
    #1;
    check("midrd_ready", 64'(ready0), 64'd0);
    check("midrd_dout", 64'(dout0), 64'd0);
    check("midrd_valid", 64'(dout_valid0), 64'd0);
    repeat (3) @(posedge clk0);

    // Test 5 / 6a: write during INIT is dropped; reset at cnt=9 restarts sweep
    @(negedge clk0);
    rst0 = 1'b0;
    repeat (2) @(posedge clk0);
    drive_write(1, 33'h1_55555555, 4'hF, 1'b1, 1'b0);
    idle(1);
    repeat (6) @(posedge clk0);
    #2;
    rst0 = 1'b1;
    #1;
    check("init_rst_ready", 64'(ready0), 64'd0);
    repeat (2) @(posedge clk0);
    release_and_count("reinit_cycles");
    for (int a = 0; a < DEPTH; a++) drive_read(a, exp_mem[a]);
    idle(LAT + 3);

    check("pending_reads", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
